// File: rtl/req_arbiter4.sv
// -----------------------------------------------------------------------------
// req_arbiter4
//
// Purpose:
//   Shares one downstream resource among four clients. Requests are sampled on
//   every rising clock edge. The winner gets a registered one-hot grant, a
//   2-bit encoded index and a valid flag. The owner keeps the grant while it
//   keeps requesting, up to MAX_HOLD consecutive cycles. After that the owner
//   is forcibly released. For that one arbitration the owner is excluded, and
//   preempt pulses for one cycle.
//
//   Winner selection:
//     - Default build: fixed priority, req[3] > req[2] > req[1] > req[0].
//     - ROUND_ROBIN_EN defined: a rotating 2-bit pointer sets the search
//       order. The pointer moves to winner+1 on every new grant.
//
// Configuration macro: ROUND_ROBIN_EN (undefined = fixed priority).
//
// Parameters:
//   MAX_HOLD  maximum consecutive grant cycles per tenure (2..15).
//
// Ports:
//   clk      in   1  system clock, rising edge
//   rst      in   1  asynchronous, active-high reset
//   req      in   4  request lines, req[i] = client i wants the resource
//   gnt      out  4  one-hot grant, zero when idle
//   gnt_idx  out  2  encoded owner index, zero when idle
//   gnt_vld  out  1  high whenever gnt is non-zero
//   preempt  out  1  one-cycle pulse in the cycle after a forced release
// -----------------------------------------------------------------------------
module req_arbiter4 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_vld,
  output logic       preempt
);

  localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] idx_q, idx_d;
  logic       vld_q, vld_d;
  logic       preempt_q, preempt_d;
  logic [3:0] hold_q, hold_d;

  logic       owner_req;
  logic       forced;
  logic [3:0] excl;
  logic [3:0] elig;
  logic [1:0] win_idx;
  logic       win_any;

  // Highest-index-first priority encoder.
  function automatic logic [1:0] pri_enc4(input logic [3:0] v);
    if (v[3])      return 2'd3;
    else if (v[2]) return 2'd2;
    else if (v[1]) return 2'd1;
    else           return 2'd0;
  endfunction

  assign owner_req = req[idx_q];
  // A hold count at or beyond the limit forces a release. In normal
  // operation the count never exceeds MAX_HOLD.
  assign forced    = (state_q == BUSY) && owner_req && (hold_q >= MAX_HOLD_C);

  // The exclusion bit applies only on the forced-release edge. On the next
  // edge the released owner competes normally again.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_excl
      assign excl[gi] = forced && (idx_q == 2'(gi));
    end
  endgenerate

  assign elig    = req & ~excl;
  assign win_any = |elig;

`ifdef ROUND_ROBIN_EN
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] rot;

  // Rotate the eligible vector so that bit 0 is the pointer position.
  // Searching from bit 0 upward then gives the order ptr, ptr+1, ptr+2, ptr+3.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_rot
      assign rot[gi] = elig[2'(ptr_q + 2'(gi))];
    end
  endgenerate

  always_comb begin
    win_idx = ptr_q;
    if (rot[0])      win_idx = ptr_q;
    else if (rot[1]) win_idx = ptr_q + 2'd1;
    else if (rot[2]) win_idx = ptr_q + 2'd2;
    else if (rot[3]) win_idx = ptr_q + 2'd3;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= 2'd0;
    else     ptr_q <= ptr_d;
  end
`else
  assign win_idx = pri_enc4(elig);
`endif

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    idx_d     = idx_q;
    vld_d     = vld_q;
    hold_d    = hold_q;
    preempt_d = forced;
`ifdef ROUND_ROBIN_EN
    ptr_d     = ptr_q;
`endif

    // Arbitrate when there is no owner, when the owner has released, or when
    // the owner has reached the tenure limit.
    if ((state_q == IDLE) || !owner_req || forced) begin
      if (win_any) begin
        state_d = BUSY;
        gnt_d   = 4'b0001 << win_idx;
        idx_d   = win_idx;
        vld_d   = 1'b1;
        hold_d  = 4'd1;
`ifdef ROUND_ROBIN_EN
        ptr_d   = win_idx + 2'd1;
`endif
      end else begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        idx_d   = 2'd0;
        vld_d   = 1'b0;
        hold_d  = 4'd0;
      end
    end else begin
      hold_d = hold_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= 4'b0000;
      idx_q     <= 2'd0;
      vld_q     <= 1'b0;
      preempt_q <= 1'b0;
      hold_q    <= 4'd0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      idx_q     <= idx_d;
      vld_q     <= vld_d;
      preempt_q <= preempt_d;
      hold_q    <= hold_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = idx_q;
  assign gnt_vld = vld_q;
  assign preempt = preempt_q;

endmodule

// File: tb/tb_req_arbiter4.sv
// -----------------------------------------------------------------------------
// tb_req_arbiter4
//
// Purpose:
//   Directed, self-checking testbench for req_arbiter4 with MAX_HOLD = 8.
//   Each scenario task drives requests and compares the DUT outputs against
//   hand-computed values. The tick task advances one clock and checks the
//   grant invariants every cycle.
//
// Configuration macro: ROUND_ROBIN_EN
//   Selects the round-robin scenario instead of the fixed-priority ones.
// -----------------------------------------------------------------------------
module tb_req_arbiter4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_vld;
  logic       preempt;

  int checks   = 0;
  int failures = 0;

  req_arbiter4 #(.MAX_HOLD(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .preempt (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and sample 1 ns later, then check the invariants.
  task automatic tick();
    logic [3:0] dec;
    @(posedge clk);
    #1;
    dec = 4'b0001 << gnt_idx;
    checks++;
    if (!((gnt == 4'b0000) || $onehot(gnt)) || (gnt_vld !== (|gnt)) ||
        (gnt_vld && (gnt !== dec)) || (!gnt_vld && (gnt_idx !== 2'd0))) begin
      failures++;
      $display("FAIL invariant: gnt=%b gnt_idx=%0d gnt_vld=%b", gnt, gnt_idx, gnt_vld);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b0000;
    tick();
    tick();
    checks++;
    if ({gnt, gnt_idx, gnt_vld, preempt} !== 8'b0) begin
      failures++;
      $display("FAIL reset_state: gnt=%b idx=%0d vld=%b preempt=%b, want all zero",
               gnt, gnt_idx, gnt_vld, preempt);
    end
    $display("reset held: gnt=%b", gnt);
    rst = 1'b0;
    req = 4'b0100;
    tick();
    checks++;
    if (gnt !== 4'b0100) begin
      failures++;
      $display("FAIL reset_pregrant: gnt=%b want 0100", gnt);
    end
    // Assert reset between clock edges. Outputs must clear without an edge.
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({gnt, gnt_idx, gnt_vld, preempt} !== 8'b0) begin
      failures++;
      $display("FAIL reset_async: gnt=%b idx=%0d vld=%b preempt=%b, want all zero",
               gnt, gnt_idx, gnt_vld, preempt);
    end
    $display("async reset mid-grant: gnt=%b", gnt);
    req = 4'b0000;
    #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (gnt !== 4'b0000 || gnt_vld !== 1'b0) begin
        failures++;
        $display("FAIL idle_after_reset[%0d]: gnt=%b vld=%b want 0000/0", i, gnt, gnt_vld);
      end
    end
  endtask

  task automatic test_short_pulse();
    // Raise and drop a request between edges; no edge sees it.
    #2;
    req = 4'b1000;
    #2;
    req = 4'b0000;
    tick();
    checks++;
    if (gnt !== 4'b0000) begin
      failures++;
      $display("FAIL short_pulse: gnt=%b want 0000", gnt);
    end
    $display("short pulse: gnt=%b", gnt);
  endtask

`ifndef ROUND_ROBIN_EN
  task automatic test_fixed_priority();
    req = 4'b0101;
    tick();
    checks++;
    if (gnt !== 4'b0100 || gnt_idx !== 2'd2 || gnt_vld !== 1'b1 || preempt !== 1'b0) begin
      failures++;
      $display("FAIL fixed_prio: gnt=%b idx=%0d vld=%b pre=%b want 0100/2/1/0",
               gnt, gnt_idx, gnt_vld, preempt);
    end
    $display("fixed priority 0101: gnt=%b idx=%0d", gnt, gnt_idx);
    req = 4'b0001;
    tick();
    checks++;
    if (gnt !== 4'b0001 || gnt_idx !== 2'd0 || gnt_vld !== 1'b1) begin
      failures++;
      $display("FAIL handoff: gnt=%b idx=%0d vld=%b want 0001/0/1", gnt, gnt_idx, gnt_vld);
    end
    $display("handoff no gap: gnt=%b idx=%0d", gnt, gnt_idx);
    req = 4'b0000;
    tick();
    checks++;
    if (gnt !== 4'b0000 || gnt_vld !== 1'b0) begin
      failures++;
      $display("FAIL release_idle: gnt=%b vld=%b want 0000/0", gnt, gnt_vld);
    end
  endtask

  task automatic test_tenure_limit();
    req = 4'b1001;
    for (int i = 1; i <= 8; i++) begin
      tick();
      checks++;
      if (gnt !== 4'b1000 || preempt !== 1'b0) begin
        failures++;
        $display("FAIL tenure_hold[%0d]: gnt=%b pre=%b want 1000/0", i, gnt, preempt);
      end
    end
    tick();
    checks++;
    if (gnt !== 4'b0001 || gnt_idx !== 2'd0 || preempt !== 1'b1) begin
      failures++;
      $display("FAIL tenure_preempt: gnt=%b idx=%0d pre=%b want 0001/0/1", gnt, gnt_idx, preempt);
    end
    $display("tenure limit: gnt=%b preempt=%b", gnt, preempt);
    tick();
    checks++;
    if (gnt !== 4'b0001 || preempt !== 1'b0) begin
      failures++;
      $display("FAIL preempt_pulse: gnt=%b pre=%b want 0001/0", gnt, preempt);
    end
    req = 4'b1000;
    tick();
    checks++;
    if (gnt !== 4'b1000 || gnt_idx !== 2'd3) begin
      failures++;
      $display("FAIL regrant_3: gnt=%b idx=%0d want 1000/3", gnt, gnt_idx);
    end
    $display("client 3 regranted: gnt=%b", gnt);
    req = 4'b0000;
    tick();
  endtask

  task automatic test_lone_preempt();
    req = 4'b0010;
    for (int i = 1; i <= 8; i++) begin
      tick();
      checks++;
      if (gnt !== 4'b0010) begin
        failures++;
        $display("FAIL lone_hold[%0d]: gnt=%b want 0010", i, gnt);
      end
    end
    tick();
    checks++;
    if (gnt !== 4'b0000 || gnt_vld !== 1'b0 || preempt !== 1'b1) begin
      failures++;
      $display("FAIL lone_idle: gnt=%b vld=%b pre=%b want 0000/0/1", gnt, gnt_vld, preempt);
    end
    $display("lone preempt idle: gnt=%b preempt=%b", gnt, preempt);
    tick();
    checks++;
    if (gnt !== 4'b0010 || preempt !== 1'b0) begin
      failures++;
      $display("FAIL lone_regrant: gnt=%b pre=%b want 0010/0", gnt, preempt);
    end
    $display("lone regrant: gnt=%b", gnt);
    req = 4'b0000;
    tick();
  endtask
`else
  task automatic test_round_robin();
    logic [1:0] exp_order [5];
    logic [3:0] exp_gnt;
    logic [3:0] r;
    exp_order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    // Start from a fresh pointer.
    rst = 1'b1;
    req = 4'b0000;
    tick();
    rst = 1'b0;
    req = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      exp_gnt = 4'b0001 << exp_order[k];
      checks++;
      if (gnt !== exp_gnt || gnt_idx !== exp_order[k]) begin
        failures++;
        $display("FAIL rr_order[%0d]: gnt=%b idx=%0d want %b/%0d", k, gnt, gnt_idx, exp_gnt, exp_order[k]);
      end
      $display("round robin step %0d: gnt=%b", k, gnt);
      tick();
      checks++;
      if (gnt !== exp_gnt) begin
        failures++;
        $display("FAIL rr_hold[%0d]: gnt=%b want %b", k, gnt, exp_gnt);
      end
      r = 4'b1111;
      r[exp_order[k]] = 1'b0;
      req = r;
      tick();
      req = 4'b1111;
    end
    req = 4'b0000;
    tick();
  endtask
`endif

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    test_reset();
    test_short_pulse();
`ifndef ROUND_ROBIN_EN
    test_fixed_priority();
    test_tenure_limit();
    test_lone_preempt();
`else
    test_round_robin();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/req_arbiter4.md
# req_arbiter4

Four-requester arbiter that shares one downstream resource among up to four clients, built around the team's 4-input priority-encoder function (request 3 highest in fixed mode). It samples requests each clock, issues a registered one-hot grant plus a 2-bit encoded grant index and valid flag, and holds the grant while the owner keeps requesting. It enforces a maximum tenure with forced preemption so no client can starve the others. It sits between the request sources and the shared datapath mux/select.

## Interface
- MAX_HOLD, 8, maximum consecutive grant cycles per tenure; legal range 2..15; 4-bit counter.
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  request lines; req[i] high = client i wants the resource.
- gnt  output  4  one-hot grant; all zero when idle.
- gnt_idx  output  2  encoded index of the current owner; 0 when idle.
- gnt_vld  output  1  high whenever gnt is non-zero; equals OR of gnt.
- preempt  output  1  one-cycle pulse in the cycle immediately following a forced release.

## Operation
- States: IDLE (no owner) and BUSY (owner = gnt_idx).
- Winner selection uses eligible requests only: req masked by the exclusion bit, where the exclusion bit is set only on a forced-release edge.
- Fixed priority: req[3] > req[2] > req[1] > req[0].
- IDLE:
  - if any eligible req, the winner is granted at the next edge and the state moves to BUSY with hold_cnt = 1;
  - otherwise the block stays in IDLE.
- BUSY, owner's req low at the edge (normal release):
  - re-arbitrate among all current reqs at the same edge;
  - on a winner, grant it directly (no dead cycle) and set hold_cnt = 1;
  - with no winner, go to IDLE.
- BUSY, owner's req high and hold_cnt < MAX_HOLD: keep the grant and increment hold_cnt.
- BUSY, owner's req high and hold_cnt == MAX_HOLD (forced release):
  - re-arbitrate with the owner excluded;
  - on a winner, grant it with hold_cnt = 1; with no winner, go to IDLE;
  - preempt = 1 for the following cycle in both cases.
  - The excluded owner may win again from the cycle after that.
- gnt, gnt_idx, gnt_vld and preempt are all registered, with no combinational path from req.
- At most one gnt bit is high in any cycle.
- Reset values, all applied asynchronously and immediately, including mid-tenure:
  - gnt = 4'b0000, gnt_idx = 2'b00, gnt_vld = 0, preempt = 0;
  - hold_cnt = 0, state = IDLE, rr pointer = 0.
- The first arbitration is at the first rising edge after rst deasserts.

## Timing
- Grant latency: 1 cycle. A req sampled high at edge k in IDLE gives gnt at edge k.
- Handoff latency: 0 idle cycles. The owner's req sampled low at edge k gives the new gnt at edge k.
- Maximum tenure: exactly MAX_HOLD consecutive gnt cycles for a continuously requesting owner.
- Worst-case wait for a requester in round-robin mode: 3 × MAX_HOLD cycles.
- Simultaneous owner release and new requests at the same edge: the new arbitration sees all reqs, including the releasing client, whose req is low and therefore not eligible.
- A req pulse shorter than one cycle that does not cover a rising edge is ignored.

## Configuration
- ROUND_ROBIN_EN defined:
  - a 2-bit rotating pointer is kept, reset to 0;
  - the search order is pointer, pointer+1, …, pointer+3, modulo 4;
  - on every new grant the pointer is set to winner+1, modulo 4.
- ROUND_ROBIN_EN undefined:
  - fixed priority 3 > 2 > 1 > 0 applies;
  - the pointer logic is not compiled in;
  - preemption and exclusion still apply.

## Test plan
- Reset/idle: rst = 1 mid-grant (gnt = 4'b0100) → outputs go to zero immediately, without waiting for a clock edge. After release with req = 0 → gnt = 0 and gnt_vld = 0 for 5 cycles.
- Fixed priority: req = 4'b0101 from IDLE → next edge gnt = 4'b0100, gnt_idx = 2, gnt_vld = 1. Drop req[2] → same edge gnt = 4'b0001, gnt_idx = 0, with no gap cycle.
- Tenure limit, MAX_HOLD = 8: req = 4'b1001 held → gnt = 4'b1000 for exactly 8 cycles, then gnt = 4'b0001 with preempt = 1 for one cycle. Client 3 is granted again at the next opportunity (fixed mode).
- Lone preempted requester: req = 4'b0010 held → 8 grant cycles, then 1 IDLE cycle with preempt = 1 and gnt = 0, then gnt = 4'b0010 again.
- Round robin (ROUND_ROBIN_EN): req = 4'b1111 held, with each owner dropping its req for one cycle after 2 grant cycles → grant order 0, 1, 2, 3, 0.
- Invariant check every cycle: gnt is one-hot or zero, gnt_vld == |gnt, and gnt_idx matches gnt.
